// File: rtl/pacman_motion.sv
// Pac-Man sprite motion: once per frame, tries the buffered direction request and
// then the current heading against the maze through a req/ack wall query.
module pacman_motion #(
   parameter int START_X = 305,
   parameter int START_Y = 225,
   parameter int STEP    = 2,
   parameter int X_MAX   = 610,
   parameter int Y_MAX   = 450
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic       wall_req,
   output logic [9:0] wall_x,
   output logic [9:0] wall_y,
   input  logic       wall_ack,
   input  logic       wall_hit,
   output logic [9:0] pm_xpos,
   output logic [9:0] pm_ypos,
   output logic [3:0] pm_direction,
   output logic       moving,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      TRY_PEND,
      WAIT_PEND,
      TRY_CUR,
      WAIT_CUR
   } state_t;

   localparam logic [3:0]  DIR_NONE  = 4'b0000;
   localparam logic [3:0]  DIR_RIGHT = 4'b0001;
   localparam logic [3:0]  DIR_LEFT  = 4'b0010;
   localparam logic [3:0]  DIR_UP    = 4'b0100;
   localparam logic [3:0]  DIR_DOWN  = 4'b1000;
   localparam logic [10:0] STEP_W    = 11'(STEP);
   localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
   localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);

   state_t     r_state;
   state_t     w_nextState;
   logic [3:0] r_pending;
   logic [3:0] r_qDir;
   logic [3:0] r_dir;
   logic [9:0] r_xpos;
   logic [9:0] r_ypos;
   logic [9:0] r_wallX;
   logic [9:0] r_wallY;
   logic       r_wallReq;
   logic       r_moving;

   logic [19:0] w_pendPos;
   logic [19:0] w_curPos;
   logic        w_pendValid;
   logic        w_pendBlocked;
   logic        w_curBlocked;
   logic        w_issue;
   logic [9:0]  w_issueX;
   logic [9:0]  w_issueY;
   logic [3:0]  w_issueDir;
   logic        w_ackDone;
   logic        w_commit;
   logic        w_takeDir;
   logic        w_noMove;

   // Saturating one-step candidate; arithmetic is one bit wider so the upper clamp cannot wrap.
   function automatic logic [19:0] nextPos(input logic [3:0] dir, input logic [9:0] x,
                                           input logic [9:0] y);
      logic [10:0] sum;
      logic [9:0]  nx;
      logic [9:0]  ny;
      nx  = x;
      ny  = y;
      sum = '0;
      case (dir)
         DIR_RIGHT: begin
            sum = {1'b0, x} + STEP_W;
            nx  = (sum > X_MAX_W) ? X_MAX_W[9:0] : sum[9:0];
         end
         DIR_LEFT:  nx = ({1'b0, x} < STEP_W) ? 10'd0 : x - STEP_W[9:0];
         DIR_UP:    ny = ({1'b0, y} < STEP_W) ? 10'd0 : y - STEP_W[9:0];
         DIR_DOWN: begin
            sum = {1'b0, y} + STEP_W;
            ny  = (sum > Y_MAX_W) ? Y_MAX_W[9:0] : sum[9:0];
         end
         default: ;
      endcase
      return {nx, ny};
   endfunction

   assign w_pendPos     = nextPos(r_pending, r_xpos, r_ypos);
   assign w_curPos      = nextPos(r_dir, r_xpos, r_ypos);
   assign w_pendValid   = (r_pending != DIR_NONE) && (r_pending != r_dir);
   assign w_pendBlocked = (w_pendPos == {r_xpos, r_ypos});
   assign w_curBlocked  = (w_curPos == {r_xpos, r_ypos});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pending <= DIR_NONE;
      end else if (btn_up) begin
         r_pending <= DIR_UP;
      end else if (btn_down) begin
         r_pending <= DIR_DOWN;
      end else if (btn_left) begin
         r_pending <= DIR_LEFT;
      end else if (btn_right) begin
         r_pending <= DIR_RIGHT;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:      if (frame_tick) w_nextState = TRY_PEND;
         TRY_PEND:  w_nextState = (w_pendValid && !w_pendBlocked) ? WAIT_PEND : TRY_CUR;
         WAIT_PEND: if (wall_ack) w_nextState = wall_hit ? TRY_CUR : IDLE;
         TRY_CUR:   w_nextState = w_curBlocked ? IDLE : WAIT_CUR;
         WAIT_CUR:  if (wall_ack) w_nextState = IDLE;
         default:   w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_issue    = 1'b0;
      w_issueX   = r_wallX;
      w_issueY   = r_wallY;
      w_issueDir = r_qDir;
      w_ackDone  = 1'b0;
      w_commit   = 1'b0;
      w_takeDir  = 1'b0;
      w_noMove   = 1'b0;
      case (r_state)
         TRY_PEND: begin
            if (w_pendValid && !w_pendBlocked) begin
               w_issue    = 1'b1;
               w_issueX   = w_pendPos[19:10];
               w_issueY   = w_pendPos[9:0];
               w_issueDir = r_pending;
            end
         end
         WAIT_PEND: begin
            if (wall_ack) begin
               w_ackDone = 1'b1;
               w_commit  = !wall_hit;
               w_takeDir = !wall_hit;
            end
         end
         TRY_CUR: begin
            if (w_curBlocked) begin
               w_noMove = 1'b1;
            end else begin
               w_issue    = 1'b1;
               w_issueX   = w_curPos[19:10];
               w_issueY   = w_curPos[9:0];
               w_issueDir = r_dir;
            end
         end
         WAIT_CUR: begin
            if (wall_ack) begin
               w_ackDone = 1'b1;
               w_commit  = !wall_hit;
               w_noMove  = wall_hit;
            end
         end
         default: ;
      endcase
   end

   // The queried direction is latched with the query so a button press mid-query cannot
   // pair a new facing with the old candidate position.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wallReq <= 1'b0;
         r_wallX   <= '0;
         r_wallY   <= '0;
         r_qDir    <= DIR_RIGHT;
         r_xpos    <= 10'(START_X);
         r_ypos    <= 10'(START_Y);
         r_dir     <= DIR_RIGHT;
         r_moving  <= 1'b0;
      end else begin
         if (w_issue) begin
            r_wallReq <= 1'b1;
            r_wallX   <= w_issueX;
            r_wallY   <= w_issueY;
            r_qDir    <= w_issueDir;
         end else if (w_ackDone) begin
            r_wallReq <= 1'b0;
         end
         if (w_commit) begin
            r_xpos   <= r_wallX;
            r_ypos   <= r_wallY;
            r_moving <= 1'b1;
            if (w_takeDir) begin
               r_dir <= r_qDir;
            end
         end else if (w_noMove) begin
            r_moving <= 1'b0;
         end
      end
   end

   assign wall_req     = r_wallReq;
   assign wall_x       = r_wallX;
   assign wall_y       = r_wallY;
   assign pm_xpos      = r_xpos;
   assign pm_ypos      = r_ypos;
   assign pm_direction = r_dir;
   assign moving       = r_moving;
   assign busy         = (r_state != IDLE);

endmodule
